tr_datapath_multiciclo: RTL and testbench

Parametrised multicycle successor of the single-cycle R-type datapath. Accepts one 32-bit instruction per handshake and executes it over 3–4 cycles through a DECODE/EXEC/MEM/WB state machine. Contains an internal register bank, ALU and word memory. Adds ADDI, LW and SW alongside R-type, plus illegal-opcode and misaligned-address error reporting. Sits below the instruction-fetch/test-harness layer.

---
 rtl/tr_datapath_multiciclo_pkg.sv | 67 ++++++
 rtl/tr_datapath_multiciclo_alu_param.sv | 28 ++
 rtl/tr_datapath_multiciclo.sv | 182 ++++++++++++++++++
 tb/tb_tr_datapath_multiciclo.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_datapath_multiciclo_pkg.sv
// Shared encodings for the multicycle datapath: opcodes, funct codes, ALU selects,
// FSM states, error codes and the instruction decoder.
package tr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_ALIGN   = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_mem;
    logic [2:0] sel;
  } dec_t;

  // LW/SW and ADDI all compute rs + sext(imm), so they share the ADD select.
  function automatic dec_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.legal  = 1'b1;
    d.is_mem = 1'b0;
    d.sel    = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  d.sel = ALU_ADD;
          FN_SUB:  d.sel = ALU_SUB;
          FN_AND:  d.sel = ALU_AND;
          FN_OR:   d.sel = ALU_OR;
          FN_NOR:  d.sel = ALU_NOR;
          FN_SLT:  d.sel = ALU_SLT;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI:      d.sel = ALU_ADD;
      OP_LW, OP_SW: d.is_mem = 1'b1;
      default:      d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tr_datapath_multiciclo_alu_param.sv
// Combinational ALU: add/sub/and/or/nor/signed set-less-than with a zero flag.
module alu_param
  import tr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] res,
  output logic              zf
);

  always_comb begin
    res = '0;
    case (sel)
      ALU_ADD: res = op1 + op2;
      ALU_SUB: res = op1 - op2;
      ALU_AND: res = op1 & op2;
      ALU_OR:  res = op1 | op2;
      ALU_NOR: res = ~(op1 | op2);
      ALU_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      default: res = '0;
    endcase
    zf = (res == '0);
  end

endmodule

// File: rtl/tr_datapath_multiciclo.sv
// Multicycle datapath: IDLE/DECODE/EXEC/MEM/WB FSM around a register bank,
// ALU and word memory; executes R-type, ADDI, LW and SW.
module tr_datapath_multiciclo
  import tr_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              busy
);

  localparam int NREG   = 1 << NREG_LOG2;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, mdr_q, mdr_d, result_q, result_d;
  logic                zf_q, zf_d, done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic [5:0]           op_s, funct_s;
  logic [NREG_LOG2-1:0] rs_s, rt_s, rd_s, wa_s;
  logic [DATA_W-1:0]    imm_ext_s, rs_val_s, alu_op2_s, alu_res_s, wdata_s;
  logic                 alu_zf_s, rf_we_s, mem_we_s;
  logic [1:0]           addr_lo_s;
  logic [MEM_AW-1:0]    mem_addr_s;
  dec_t                 dec_s;

  assign op_s       = ir_q[31:26];
  assign funct_s    = ir_q[5:0];
  assign rs_s       = ir_q[21 +: NREG_LOG2];
  assign rt_s       = ir_q[16 +: NREG_LOG2];
  assign rd_s       = ir_q[11 +: NREG_LOG2];
  assign imm_ext_s  = DATA_W'($signed(ir_q[15:0]));
  assign dec_s      = decode_instr(op_s, funct_s);
  assign rs_val_s   = rf_q[rs_s];
  // Low address bits are known in DECODE, so a misaligned access can end in EXEC.
  assign addr_lo_s  = rs_val_s[1:0] + ir_q[1:0];
  assign mem_addr_s = result_q[MEM_AW+1:2];
  assign alu_op2_s  = (op_s == OP_RTYPE) ? b_q : imm_ext_s;
  assign wa_s       = (op_s == OP_RTYPE) ? rd_s : rt_s;
  assign wdata_s    = (op_s == OP_LW) ? mdr_q : result_q;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .op1 (a_q),
    .op2 (alu_op2_s),
    .sel (dec_s.sel),
    .res (alu_res_s),
    .zf  (alu_zf_s)
  );

  // done/err are set on entry to the instruction's final state so they are registered.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    mdr_d    = mdr_q;
    result_d = result_q;
    zf_d     = zf_q;
    done_d   = 1'b0;
    err_d    = ERR_OK;
    rf_we_s  = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        a_d     = rs_val_s;
        b_d     = rf_q[rt_s];
        state_d = EXEC;
        if (!dec_s.legal) begin
          done_d = 1'b1;
          err_d  = ERR_ILLEGAL;
        end else if (dec_s.is_mem && (addr_lo_s != 2'd0)) begin
          done_d = 1'b1;
          err_d  = ERR_ALIGN;
        end else begin
          done_d = 1'b0;
          err_d  = ERR_OK;
        end
      end
      EXEC: begin
        if (err_q == ERR_ILLEGAL) begin
          state_d = IDLE;
        end else begin
          result_d = alu_res_s;
          zf_d     = alu_zf_s;
          if (err_q == ERR_ALIGN) begin
            state_d = IDLE;
          end else if (dec_s.is_mem) begin
            state_d = MEM;
            done_d  = (op_s == OP_SW);
          end else begin
            state_d = WB;
            done_d  = 1'b1;
          end
        end
      end
      MEM: begin
        if (op_s == OP_LW) begin
          mdr_d   = mem_q[mem_addr_s];
          state_d = WB;
          done_d  = 1'b1;
        end else begin
          mem_we_s = 1'b1;
          state_d  = IDLE;
        end
      end
      WB: begin
        rf_we_s = (wa_s != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mdr_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mdr_q    <= mdr_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Register bank; entry 0 is never written so it always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we_s) begin
      rf_q[wa_s] <= wdata_s;
    end
  end

  // Word memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[mem_addr_s] <= b_q;
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign zf          = zf_q;

endmodule

// File: tb/tb_tr_datapath_multiciclo.sv
// Self-checking bench: directed scenarios plus random instruction streams checked
// against an instruction-level reference model.
module tb_tr_datapath_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready, done, zf, busy;
  logic [1:0]  err;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tr_datapath_multiciclo #(.DATA_W(32), .NREG_LOG2(5), .MEM_DEPTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .result      (result),
    .zf          (zf),
    .busy        (busy)
  );

  typedef struct {
    int          lat;
    logic [1:0]  e;
    logic [31:0] res;
    logic        z;
    logic        pulse_ok;
    logic        ready_after;
    logic        timeout;
  } obs_t;

  // Reference model: architectural state only.
  logic [31:0] mreg [32];
  logic [31:0] mmem [64];
  logic [31:0] mres;
  logic        mzf;

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mres = 32'd0;
    mzf  = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] ins, output int lat, output logic [1:0] e);
    logic [5:0]  op, fn;
    int          rs, rt, rd, dst;
    logic [31:0] a, b, s, r, wv;
    logic        legal, wr;
    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    a = mreg[rs]; b = mreg[rt]; s = {{16{ins[15]}}, ins[15:0]};
    legal = 1'b1; wr = 1'b0; dst = 0; e = 2'd0; lat = 2; r = 32'd0;
    if (op == 6'h00) begin
      dst = rd; wr = 1'b1; lat = 3;
      case (fn)
        6'h20:   r = a + b;
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h27:   r = ~(a | b);
        6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: legal = 1'b0;
      endcase
    end else if (op == 6'h08) begin
      r = a + s; dst = rt; wr = 1'b1; lat = 3;
    end else if (op == 6'h23 || op == 6'h2B) begin
      r = a + s;
      if (r[1:0] != 2'd0) e = 2'd2;
      else if (op == 6'h23) begin dst = rt; wr = 1'b1; lat = 4; end
      else begin mmem[r[7:2]] = b; lat = 3; end
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e = 2'd1; lat = 2; wr = 1'b0;
    end else begin
      mres = r; mzf = (r == 32'd0);
    end
    wv = (op == 6'h23) ? mmem[r[7:2]] : r;
    if (wr && dst != 0) mreg[dst] = wv;
  endtask

  // Starts and ends at a falling edge; samples result one cycle after done.
  task automatic send(input logic [31:0] ins, input logic hold, input logic [31:0] alt, output obs_t o);
    int   n;
    logic seen;
    o.timeout = 1'b0;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) o.timeout = 1'b1;
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) instr = alt; else instr_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin @(negedge clk); n++; if (done) seen = 1'b1; end
    if (!seen) o.timeout = 1'b1;
    o.lat = n; o.e = err;
    instr_valid = 1'b0;
    @(negedge clk);
    o.res = result; o.z = zf; o.pulse_ok = !done; o.ready_after = instr_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({done, err, result, zf, busy, instr_ready} !== {1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got done=%0b err=%0d result=%0h zf=%0b busy=%0b ready=%0b, expected 0 0 0 0 0 1",
               done, err, result, zf, busy, instr_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_memory();
    obs_t o; int xl; logic [1:0] xe; logic [31:0] ins;
    for (int k = 0; k < 64; k++) begin
      ins = enc_i(6'h2B, 0, 0, 16'(k * 4));
      model_step(ins, xl, xe);
      send(ins, 1'b0, 32'd0, o);
      checks++;
      if (o.timeout || o.lat != xl || o.e !== xe) begin
        errors++;
        $display("FAIL fill_sw[%0d]: got lat=%0d err=%0d timeout=%0b, expected lat=%0d err=%0d", k, o.lat, o.e, o.timeout, xl, xe);
      end
    end
  endtask

  task automatic test_alu_basic();
    logic [31:0] tin [5]; logic [31:0] tres [5]; logic tz [5];
    obs_t o; int xl; logic [1:0] xe;
    tin  = '{enc_i(6'h08, 1, 0, 16'd5), enc_i(6'h08, 2, 0, 16'hFFFD), enc_r(3, 1, 2, 6'h20),
             enc_r(4, 1, 1, 6'h22), enc_r(5, 2, 1, 6'h2A)};
    tres = '{32'd5, 32'hFFFFFFFD, 32'd2, 32'd0, 32'd1};
    tz   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      model_step(tin[i], xl, xe);
      send(tin[i], 1'b0, 32'd0, o);
      checks++;
      if (o.timeout || o.lat != 3 || o.e !== 2'd0 || o.res !== tres[i] || o.z !== tz[i]) begin
        errors++;
        $display("FAIL alu_basic[%0d]: got lat=%0d err=%0d result=%0h zf=%0b, expected lat=3 err=0 result=%0h zf=%0b",
                 i, o.lat, o.e, o.res, o.z, tres[i], tz[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [31:0] tin [11]; int tlat [11]; logic [1:0] terr [11]; logic [31:0] tres [11];
    obs_t o; int xl; logic [1:0] xe;
    tin  = '{enc_i(6'h2B, 1, 0, 16'd8), enc_i(6'h23, 6, 0, 16'd8), enc_r(7, 6, 0, 6'h20),
             enc_i(6'h23, 6, 0, 16'd6), enc_r(9, 6, 0, 6'h20), enc_i(6'h2B, 2, 0, 16'd6),
             enc_i(6'h23, 10, 0, 16'd4), enc_r(11, 10, 0, 6'h20), enc_i(6'h2B, 2, 0, 16'h0104),
             enc_i(6'h23, 10, 0, 16'd4), enc_r(11, 10, 0, 6'h20)};
    tlat = '{3, 4, 3, 2, 3, 2, 4, 3, 3, 4, 3};
    terr = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    tres = '{32'd8, 32'd8, 32'd5, 32'd6, 32'd5, 32'd6, 32'd4, 32'd0, 32'h104, 32'd4, 32'hFFFFFFFD};
    for (int i = 0; i < 11; i++) begin
      model_step(tin[i], xl, xe);
      send(tin[i], 1'b0, 32'd0, o);
      checks++;
      if (o.timeout || o.lat != tlat[i] || o.e !== terr[i] || o.res !== tres[i]) begin
        errors++;
        $display("FAIL mem[%0d]: got lat=%0d err=%0d result=%0h, expected lat=%0d err=%0d result=%0h",
                 i, o.lat, o.e, o.res, tlat[i], terr[i], tres[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] tin [5]; int tlat [5]; logic [1:0] terr [5]; logic [31:0] tres [5];
    obs_t o; int xl; logic [1:0] xe;
    tin  = '{enc_r(12, 1, 0, 6'h20), enc_i(6'h3F, 1, 2, 16'h1234), enc_r(1, 2, 2, 6'h00),
             enc_r(1, 1, 0, 6'h01), enc_r(12, 1, 2, 6'h22)};
    tlat = '{3, 2, 2, 2, 3};
    terr = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    tres = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd8};
    for (int i = 0; i < 5; i++) begin
      model_step(tin[i], xl, xe);
      send(tin[i], 1'b0, 32'd0, o);
      checks++;
      if (o.timeout || o.lat != tlat[i] || o.e !== terr[i] || o.res !== tres[i] || !o.pulse_ok) begin
        errors++;
        $display("FAIL illegal[%0d]: got lat=%0d err=%0d result=%0h single_pulse=%0b, expected lat=%0d err=%0d result=%0h single_pulse=1",
                 i, o.lat, o.e, o.res, o.pulse_ok, tlat[i], terr[i], tres[i]);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    obs_t o; int xl; logic [1:0] xe; logic [31:0] ins;
    ins = enc_i(6'h08, 13, 0, 16'h0011);
    model_step(ins, xl, xe);
    send(ins, 1'b1, enc_i(6'h08, 14, 0, 16'h0022), o);
    checks++;
    if (o.timeout || o.lat != 3 || o.res !== 32'h11) begin
      errors++;
      $display("FAIL ignore_held: got lat=%0d result=%0h, expected lat=3 result=11", o.lat, o.res);
    end
    ins = enc_r(15, 14, 0, 6'h20);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    checks++;
    if (o.timeout || o.res !== 32'd0 || o.z !== 1'b1) begin
      errors++;
      $display("FAIL ignore_r14: got result=%0h zf=%0b, expected result=0 zf=1", o.res, o.z);
    end
  endtask

  task automatic test_r0();
    obs_t o; int xl; logic [1:0] xe; logic [31:0] ins;
    ins = enc_i(6'h08, 0, 0, 16'd7);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    checks++;
    if (o.timeout || o.lat != 3 || o.e !== 2'd0 || o.res !== 32'd7) begin
      errors++;
      $display("FAIL r0_addi: got lat=%0d err=%0d result=%0h, expected lat=3 err=0 result=7", o.lat, o.e, o.res);
    end
    ins = enc_r(8, 0, 0, 6'h20);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    checks++;
    if (o.timeout || o.res !== 32'd0 || o.z !== 1'b1) begin
      errors++;
      $display("FAIL r0_read: got result=%0h zf=%0b, expected result=0 zf=1", o.res, o.z);
    end
  endtask

  task automatic test_reset_mid_instr();
    obs_t o; int xl; logic [1:0] xe; logic [31:0] ins;
    instr = enc_r(3, 1, 2, 6'h20); instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: got busy=%0b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, instr_ready, done, result, zf} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_state: got busy=%0b ready=%0b done=%0b result=%0h zf=%0b, expected 0 1 0 0 0",
               busy, instr_ready, done, result, zf);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got instr_ready=%0b, expected 1", instr_ready);
    end
    ins = enc_r(16, 3, 0, 6'h20);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    checks++;
    if (o.timeout || o.lat != 3 || o.res !== 32'd0 || o.z !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_r3: got lat=%0d result=%0h zf=%0b, expected lat=3 result=0 zf=1", o.lat, o.res, o.z);
    end
    ins = enc_i(6'h23, 17, 0, 16'd8);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    ins = enc_r(18, 17, 0, 6'h20);
    model_step(ins, xl, xe);
    send(ins, 1'b0, 32'd0, o);
    checks++;
    if (o.timeout || o.res !== 32'd5) begin
      errors++;
      $display("FAIL rst_mid_mem_kept: got result=%0h, expected 5", o.res);
    end
  endtask

  task automatic test_random();
    logic [5:0]  fns [7];
    logic [5:0]  op;
    logic [31:0] ins;
    int          kind, xl;
    logic [1:0]  xe;
    obs_t        o;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2A};
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) begin
        ins = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 15) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)]);
      end else if (kind <= 6) begin
        ins = enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
      end else if (kind <= 8) begin
        op = (kind == 7) ? 6'h23 : 6'h2B;
        if ($urandom_range(0, 1) == 0)
          ins = enc_i(op, int'($urandom_range(0, 7)), 0, 16'($urandom_range(0, 200) * 4));
        else
          ins = enc_i(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom_range(0, 1023)));
      end else begin
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B) op = 6'($urandom);
        ins = enc_i(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
      end
      model_step(ins, xl, xe);
      send(ins, 1'b0, 32'd0, o);
      checks++;
      if (o.timeout || o.lat != xl || o.e !== xe || o.res !== mres || o.z !== mzf || !o.pulse_ok || !o.ready_after) begin
        errors++;
        $display("FAIL random[%0d] instr=%08h: got lat=%0d err=%0d result=%0h zf=%0b pulse=%0b ready=%0b, expected lat=%0d err=%0d result=%0h zf=%0b pulse=1 ready=1",
                 n, ins, o.lat, o.e, o.res, o.z, o.pulse_ok, o.ready_after, xl, xe, mres, mzf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_memory();
    test_alu_basic();
    test_mem();
    test_illegal();
    test_ignore_while_busy();
    test_r0();
    test_reset_mid_instr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
